// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared types and helpers for the line-granular backing memory.
//   state_e   - controller states (IDLE, BUSY, DONE)
//   op_e      - latched transaction kind (OP_RD, OP_WR)
//   init_word - power-up content of a given word within a given line
package line_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  localparam int unsigned CNT_W = 8;

  function automatic logic [31:0] init_word(input logic [31:0] line,
                                            input logic [31:0] word,
                                            input int unsigned line_addr_len);
    return (line << line_addr_len) | word;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// line_mem_array: line-wide storage for line_mem.
// Ports:
//   clk      - write clock
//   we_i     - write enable, commits wdata_i to line waddr_i on the rising edge
//   waddr_i  - line write address
//   wdata_i  - line write data (packed, word 0 in the low bits)
//   raddr_i  - line read address (asynchronous read)
//   rdata_o  - line read data
// Power-up contents follow init_word(); reset never touches the store.
module line_mem_array import line_mem_pkg::*; #(
  parameter int unsigned LINE_ADDR_LEN = 4,
  parameter int unsigned ADDR_LEN      = 10
) (
  input  logic                                  clk,
  input  logic                                  we_i,
  input  logic [ADDR_LEN-1:0]                   waddr_i,
  input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   wdata_i,
  input  logic [ADDR_LEN-1:0]                   raddr_i,
  output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   rdata_o
);

  localparam int unsigned LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int unsigned NLINES    = 1 << ADDR_LEN;

  typedef logic [LINE_SIZE-1:0][31:0] line_t;

  // Each line is kept as its XOR difference from the init pattern, so the
  // all-zero power-up value of the store reads back as the pattern.
  line_t delta_q [NLINES] = '{default: '0};

  function automatic line_t pattern(input logic [ADDR_LEN-1:0] a);
    line_t p;
    for (int unsigned w = 0; w < LINE_SIZE; w++) begin
      p[w] = init_word(32'(a), w, LINE_ADDR_LEN);
    end
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (we_i) begin
      delta_q[waddr_i] <= wdata_i ^ pattern(waddr_i);
    end
  end

  always_comb begin
    rdata_o = delta_q[raddr_i] ^ pattern(raddr_i);
  end

endmodule

// File: rtl/line_mem.sv
// line_mem: line-granular backing memory below the set-associative cache.
// Serves one whole-line read or write at a time with a fixed LATENCY and a
// one-cycle gnt completion pulse.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (does not clear the store)
//   gnt      - one-cycle completion pulse (decoded from the DONE state)
//   addr     - line address, sampled at accept
//   rd_req   - line read request, held until gnt
//   rd_line  - read data, held until the next read completes
//   wr_req   - line write request, held until gnt
//   wr_line  - write data, sampled at accept
// Build option: define LINE_MEM_STATS_EN to add saturating rd_cnt, wr_cnt
// and drop_cnt transaction counters.
module line_mem import line_mem_pkg::*; #(
  parameter int unsigned LINE_ADDR_LEN = 4,
  parameter int unsigned ADDR_LEN      = 10,
  parameter int unsigned LATENCY       = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                gnt,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  output logic [31:0]         rd_line [1<<LINE_ADDR_LEN],
  input  logic                wr_req,
  input  logic [31:0]         wr_line [1<<LINE_ADDR_LEN]
);

  localparam int unsigned LINE_SIZE = 1 << LINE_ADDR_LEN;

  typedef logic [LINE_SIZE-1:0][31:0] line_t;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  op_e                 op_q;
  logic [ADDR_LEN-1:0] addr_q;
  line_t               wdata_q;
  line_t               rd_line_q;

  line_t               wr_line_p;
  line_t               arr_rdata;
  logic                accept;
  op_e                 acc_op;
  logic                enter_done;
  op_e                 cur_op;
  logic [ADDR_LEN-1:0] cur_addr;
  line_t               cur_wdata;
  logic                mem_we;

  always_comb begin
    for (int unsigned k = 0; k < LINE_SIZE; k++) begin
      wr_line_p[k] = wr_line[k];
      rd_line[k]   = rd_line_q[k];
    end
  end

  assign accept = (state_q == IDLE) && (rd_req || wr_req);
  assign acc_op = rd_req ? OP_RD : OP_WR;

  // With LATENCY == 1 the accepting edge is also the edge entering DONE, so
  // the commit/load uses the live request rather than the latched copy.
  always_comb begin
    enter_done = ((state_q == BUSY) && (cnt_q == '0)) || (accept && (LATENCY == 1));
    if (state_q == IDLE) begin
      cur_op    = acc_op;
      cur_addr  = addr;
      cur_wdata = wr_line_p;
    end else begin
      cur_op    = op_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    mem_we = enter_done && (cur_op == OP_WR);
  end

  line_mem_array #(
    .LINE_ADDR_LEN (LINE_ADDR_LEN),
    .ADDR_LEN      (ADDR_LEN)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (cur_addr),
    .wdata_i (cur_wdata),
    .raddr_i (cur_addr),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_line_q <= '0;
    end else begin
      if (enter_done && (cur_op == OP_RD)) begin
        rd_line_q <= arr_rdata;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= addr;
            op_q    <= acc_op;
            wdata_q <= wr_line_p;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt = (state_q == DONE);

`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      drop_cnt <= '0;
    end else if (accept) begin
      if ((acc_op == OP_RD) && (rd_cnt != '1)) rd_cnt <= rd_cnt + 32'd1;
      if ((acc_op == OP_WR) && (wr_cnt != '1)) wr_cnt <= wr_cnt + 32'd1;
      if (rd_req && wr_req && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_line_mem.sv
module tb_line_mem;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        gnt0, rd0, wr0;
  logic [9:0]  addr0;
  logic [31:0] rdl0 [16];
  logic [31:0] wrl0 [16];

  logic        gnt1, rd1, wr1;
  logic [9:0]  addr1;
  logic [31:0] rdl1 [16];
  logic [31:0] wrl1 [16];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  line_mem #(.LINE_ADDR_LEN(4), .ADDR_LEN(10), .LATENCY(50)) dut0 (
    .clk(clk), .rst_n(rst_n), .gnt(gnt0), .addr(addr0),
    .rd_req(rd0), .rd_line(rdl0), .wr_req(wr0), .wr_line(wrl0)
  );

  line_mem #(.LINE_ADDR_LEN(4), .ADDR_LEN(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .gnt(gnt1), .addr(addr1),
    .rd_req(rd1), .rd_line(rdl1), .wr_req(wr1), .wr_line(wrl1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_line0(input string tag, input logic [31:0] base);
    for (int k = 0; k < 16; k++) chk($sformatf("%s[%0d]", tag, k), rdl0[k], base + 32'(k));
  endtask

  task automatic chk_line1(input string tag, input logic [31:0] base);
    for (int k = 0; k < 16; k++) chk($sformatf("%s[%0d]", tag, k), rdl1[k], base + 32'(k));
  endtask

  // One full LATENCY=50 transaction on dut0: accept, 50 samples without gnt,
  // gnt on the 51st, requests dropped, back in IDLE on return.
  task automatic run0(input string tag, input logic r, input logic w,
                      input logic [9:0] a, input logic [31:0] base);
    int hi;
    for (int k = 0; k < 16; k++) wrl0[k] = base + 32'(k);
    rd0 = r; wr0 = w; addr0 = a;
    tick();
    hi = int'(gnt0);
    repeat (49) begin tick(); hi += int'(gnt0); end
    chk({tag, "_wait"}, hi, 0);
    tick();
    chk({tag, "_gnt"}, gnt0, 1);
    rd0 = 0; wr0 = 0;
    tick();
    chk({tag, "_gnt_off"}, gnt0, 0);
  endtask

  initial begin
    int hi, hi2, bad;
    logic [7:0] pat;

    rst_n = 0;
    rd0 = 0; wr0 = 0; addr0 = '0;
    rd1 = 0; wr1 = 0; addr1 = '0;
    for (int k = 0; k < 16; k++) begin wrl0[k] = '0; wrl1[k] = '0; end
    tick(); tick();
    chk("rst_gnt", gnt0, 0);
    chk("rst_rdl0", rdl0[0], 32'h0);
    chk("rst_rdl5", rdl0[5], 32'h0);
    rst_n = 1;
    tick();

    // Read line 3; hold rd_req through the DONE cycle, which must be ignored.
    addr0 = 10'd3; rd0 = 1;
    tick();
    hi = int'(gnt0);
    repeat (49) begin tick(); hi += int'(gnt0); end
    chk("t1_wait", hi, 0);
    tick();
    chk("t1_gnt", gnt0, 1);
    chk("t1_rd5", rdl0[5], 32'h35);
    tick();
    chk("t1_gnt_once", gnt0, 0);
    rd0 = 0;
    hi = 0; bad = 0;
    repeat (10) begin
      tick();
      hi += int'(gnt0);
      if (rdl0[5] !== 32'h35) bad++;
    end
    chk("t1_idle_gnt", hi, 0);
    chk("t1_hold_bad", bad, 0);

    // Swap-out line 7 then swap-in on the IDLE cycle after gnt.
    run0("t2_wr", 0, 1, 10'd7, 32'hA000);
    chk("t2_rd_kept", rdl0[5], 32'h35);
    run0("t2_rd", 1, 0, 10'd7, 32'h0);
    chk_line0("t2_line7", 32'hA000);

    // Write line 7; drop wr_req and move addr to 9 mid-transaction.
    for (int k = 0; k < 16; k++) wrl0[k] = 32'hB000 + 32'(k);
    addr0 = 10'd7; wr0 = 1;
    tick();
    hi = int'(gnt0);
    repeat (9) begin tick(); hi += int'(gnt0); end
    wr0 = 0; addr0 = 10'd9;
    for (int k = 0; k < 16; k++) wrl0[k] = 32'hEEEE;
    repeat (40) begin tick(); hi += int'(gnt0); end
    chk("t3_wait", hi, 0);
    tick();
    chk("t3_gnt", gnt0, 1);
    tick();
    chk("t3_gnt_off", gnt0, 0);
    run0("t3_rd7", 1, 0, 10'd7, 32'h0);
    chk_line0("t3_line7", 32'hB000);
    run0("t3_rd9", 1, 0, 10'd9, 32'h0);
    chk_line0("t3_line9", 32'h90);

    // LATENCY = 1: continuous read of line 2 grants every other cycle.
    addr1 = 10'd2; rd1 = 1;
    tick();
    chk("t4_rd0", rdl1[0], 32'h20);
    pat = '0;
    for (int i = 0; i < 8; i++) begin pat[i] = gnt1; tick(); end
    chk("t4_pattern", {24'h0, pat}, 32'h55);
    rd1 = 0;
    tick(); tick();
    chk("t4_idle", gnt1, 0);
    for (int k = 0; k < 16; k++) wrl1[k] = 32'h5500 + 32'(k);
    addr1 = 10'd5; wr1 = 1;
    tick();
    chk("t4_wr_gnt", gnt1, 1);
    chk("t4_wr_rdkeep", rdl1[0], 32'h20);
    wr1 = 0;
    tick();
    rd1 = 1;
    tick();
    chk("t4_rd_gnt", gnt1, 1);
    chk_line1("t4_line5", 32'h5500);
    rd1 = 0;
    tick();

    // Both requests at accept: read wins, write dropped.
    rst_n = 0;
    tick();
    chk("t5_rst_rdl", rdl0[0], 32'h0);
    rst_n = 1;
    tick();
    run0("t5_both", 1, 1, 10'd4, 32'hDEAD0000);
    chk_line0("t5_rd4", 32'h40);
`ifdef LINE_MEM_STATS_EN
    chk("t5_drop_cnt", dut0.drop_cnt, 32'd1);
    chk("t5_rd_cnt", dut0.rd_cnt, 32'd1);
    chk("t5_wr_cnt", dut0.wr_cnt, 32'd0);
`endif
    run0("t5_rd4b", 1, 0, 10'd4, 32'h0);
    chk_line0("t5_line4", 32'h40);

    // Reset during a write to line 6 aborts it.
    for (int k = 0; k < 16; k++) wrl0[k] = 32'hC000 + 32'(k);
    addr0 = 10'd6; wr0 = 1;
    tick();
    hi = int'(gnt0);
    repeat (19) begin tick(); hi += int'(gnt0); end
    rst_n = 0;
    #1;
    chk("t6_rst_gnt", gnt0, 0);
    chk("t6_rst_rdl", rdl0[0], 32'h0);
    tick();
    wr0 = 0;
    tick();
    rst_n = 1;
    hi2 = 0;
    repeat (45) begin tick(); hi2 += int'(gnt0); end
    chk("t6_no_gnt", hi + hi2, 0);
    run0("t6_rd6", 1, 0, 10'd6, 32'h0);
    chk_line0("t6_line6", 32'h60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
